// File: rtl/result_writeback_pkg.sv
// Shared types for the result writeback path: the buffered result entry and drain phase.
package result_writeback_pkg;

  localparam int GPR_AW_DEF     = 5;
  localparam int CRF_FIELDS_DEF = 8;
  localparam int CRF_SEL_W_DEF  = $clog2(CRF_FIELDS_DEF);

  // Entry layout for the default register-file configuration.
  typedef struct packed {
    logic [31:0]              res_a;
    logic [31:0]              res_b;
    logic                     wr_a;
    logic                     wr_b;
    logic [GPR_AW_DEF-1:0]    dest_a;
    logic [GPR_AW_DEF-1:0]    dest_b;
    logic                     wr_crf;
    logic [CRF_SEL_W_DEF-1:0] crf_sel;
    logic [3:0]               crf;
  } wb_entry_t;

  typedef enum logic {PH_A, PH_B} wb_phase_t;

endpackage

// File: rtl/result_writeback_fifo.sv
// Generic synchronous FIFO with a combinational head; pointers wrap naturally (DEPTH is a power of two).
module wb_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  T                             push_data,
  input  logic                         pop,
  output T                             head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/result_writeback.sv
// Buffers FU results and drains each one through the single GPR write port (A beat, then B beat),
// with the CR field write issued once per entry on a separate always-accepting port.
module result_writeback
  import result_writeback_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int GPR_AW     = GPR_AW_DEF,
  parameter int CRF_FIELDS = CRF_FIELDS_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rb_valid,
  input  logic [31:0]                   rb_res_a,
  input  logic [31:0]                   rb_res_b,
  input  logic                          rb_wr_a,
  input  logic                          rb_wr_b,
  input  logic [GPR_AW-1:0]             rb_dest_a,
  input  logic [GPR_AW-1:0]             rb_dest_b,
  input  logic                          rb_wr_crf,
  input  logic [$clog2(CRF_FIELDS)-1:0] rb_crf_sel,
  input  logic [3:0]                    rb_crf,
  output logic                          stall,
  output logic                          gpr_we,
  output logic [GPR_AW-1:0]             gpr_waddr,
  output logic [31:0]                   gpr_wdata,
  input  logic                          gpr_ready,
  output logic                          crf_we,
  output logic [$clog2(CRF_FIELDS)-1:0] crf_sel,
  output logic [3:0]                    crf_wdata,
  output logic                          overflow_err
);

  localparam int SEL_W = $clog2(CRF_FIELDS);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [31:0]       res_a;
    logic [31:0]       res_b;
    logic              wr_a;
    logic              wr_b;
    logic [GPR_AW-1:0] dest_a;
    logic [GPR_AW-1:0] dest_b;
    logic              wr_crf;
    logic [SEL_W-1:0]  crf_sel;
    logic [3:0]        crf;
  } entry_t;

  entry_t           in_entry;
  entry_t           head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             to_b;
  wb_phase_t        phase;
  logic             crf_done;

  assign in_entry = '{res_a: rb_res_a, res_b: rb_res_b, wr_a: rb_wr_a, wr_b: rb_wr_b,
                      dest_a: rb_dest_a, dest_b: rb_dest_b, wr_crf: rb_wr_crf,
                      crf_sel: rb_crf_sel, crf: rb_crf};

  assign stall = (fifo_count == CNT_W'(DEPTH));
  assign push  = rb_valid && !fifo_full;

  wb_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (in_entry),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // An entry without wr_a is served directly by the B beat; an entry with no GPR writes pops at once.
  always_comb begin
    gpr_we    = 1'b0;
    gpr_waddr = '0;
    gpr_wdata = '0;
    crf_we    = 1'b0;
    crf_sel   = '0;
    crf_wdata = '0;
    pop       = 1'b0;
    to_b      = 1'b0;
    if (!fifo_empty) begin
      if (head.wr_crf && !crf_done) begin
        crf_we    = 1'b1;
        crf_sel   = head.crf_sel;
        crf_wdata = head.crf;
      end
      if (phase == PH_A && head.wr_a) begin
        gpr_we    = 1'b1;
        gpr_waddr = head.dest_a;
        gpr_wdata = head.res_a;
        if (gpr_ready) begin
          to_b = head.wr_b;
          pop  = !head.wr_b;
        end
      end else if (head.wr_b) begin
        gpr_we    = 1'b1;
        gpr_waddr = head.dest_b;
        gpr_wdata = head.res_b;
        pop       = gpr_ready;
      end else begin
        pop = 1'b1;
      end
    end
  end

  // crf_done remembers that this head's CR write already went out, so it fires once per entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase        <= PH_A;
      crf_done     <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      if (rb_valid && stall) overflow_err <= 1'b1;
      if (pop) begin
        phase    <= PH_A;
        crf_done <= 1'b0;
      end else begin
        if (to_b)   phase    <= PH_B;
        if (crf_we) crf_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_result_writeback.sv
// Drives directed and random result traffic into result_writeback and compares every cycle
// against a queue-based model of pending results and their GPR/CR writes.
module tb_result_writeback;
  import result_writeback_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        rb_valid;
  logic [31:0] rb_res_a;
  logic [31:0] rb_res_b;
  logic        rb_wr_a;
  logic        rb_wr_b;
  logic [4:0]  rb_dest_a;
  logic [4:0]  rb_dest_b;
  logic        rb_wr_crf;
  logic [2:0]  rb_crf_sel;
  logic [3:0]  rb_crf;
  logic        stall;
  logic        gpr_we;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        gpr_ready;
  logic        crf_we;
  logic [2:0]  crf_sel;
  logic [3:0]  crf_wdata;
  logic        overflow_err;

  int tests_run = 0;
  int tests_failed = 0;

  wb_entry_t model_q[$];
  int        beats_done = 0;
  bit        crf_seen = 0;
  bit        ovf_model = 0;

  result_writeback #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .rb_valid     (rb_valid),
    .rb_res_a     (rb_res_a),
    .rb_res_b     (rb_res_b),
    .rb_wr_a      (rb_wr_a),
    .rb_wr_b      (rb_wr_b),
    .rb_dest_a    (rb_dest_a),
    .rb_dest_b    (rb_dest_b),
    .rb_wr_crf    (rb_wr_crf),
    .rb_crf_sel   (rb_crf_sel),
    .rb_crf       (rb_crf),
    .stall        (stall),
    .gpr_we       (gpr_we),
    .gpr_waddr    (gpr_waddr),
    .gpr_wdata    (gpr_wdata),
    .gpr_ready    (gpr_ready),
    .crf_we       (crf_we),
    .crf_sel      (crf_sel),
    .crf_wdata    (crf_wdata),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // A result's GPR writes, in order: A first (if requested), then B.
  function automatic int num_beats(input wb_entry_t e);
    return int'(e.wr_a) + int'(e.wr_b);
  endfunction

  task automatic check_model();
    wb_entry_t h;
    bit        exp_we;
    bit        exp_crf;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    exp_we = 0; exp_crf = 0; exp_addr = '0; exp_data = '0;
    h = '0;
    if (model_q.size() > 0) begin
      h = model_q[0];
      exp_we  = beats_done < num_beats(h);
      exp_crf = h.wr_crf && !crf_seen;
      if (beats_done == 0 && h.wr_a) begin
        exp_addr = h.dest_a; exp_data = h.res_a;
      end else begin
        exp_addr = h.dest_b; exp_data = h.res_b;
      end
    end
    checkOutput("stall", stall, (model_q.size() == DEPTH));
    checkOutput("overflow_err", overflow_err, ovf_model);
    checkOutput("gpr_we", gpr_we, exp_we);
    if (exp_we) begin
      checkOutput("gpr_waddr", gpr_waddr, exp_addr);
      checkOutput("gpr_wdata", gpr_wdata, exp_data);
    end
    checkOutput("crf_we", crf_we, exp_crf);
    if (exp_crf) begin
      checkOutput("crf_sel", crf_sel, h.crf_sel);
      checkOutput("crf_wdata", crf_wdata, h.crf);
    end
  endtask

  task automatic update_model(input bit v, input wb_entry_t e, input bit rdy, input bit rst);
    int old_size;
    if (rst) begin
      model_q.delete();
      beats_done = 0; crf_seen = 0; ovf_model = 0;
      return;
    end
    old_size = model_q.size();
    if (old_size > 0) begin
      crf_seen = 1;
      if (beats_done < num_beats(model_q[0]) && rdy) beats_done++;
      if (beats_done >= num_beats(model_q[0])) begin
        void'(model_q.pop_front());
        beats_done = 0; crf_seen = 0;
      end
    end
    if (v) begin
      if (old_size == DEPTH) ovf_model = 1;
      else model_q.push_back(e);
    end
  endtask

  task automatic applyStimulus(input bit v, input wb_entry_t e, input bit rdy, input bit rst);
    reset      = rst;
    rb_valid   = v;
    rb_res_a   = e.res_a;
    rb_res_b   = e.res_b;
    rb_wr_a    = e.wr_a;
    rb_wr_b    = e.wr_b;
    rb_dest_a  = e.dest_a;
    rb_dest_b  = e.dest_b;
    rb_wr_crf  = e.wr_crf;
    rb_crf_sel = e.crf_sel;
    rb_crf     = e.crf;
    gpr_ready  = rdy;
    #2;
    if (!rst) check_model();
    update_model(v, e, rdy, rst);
    @(posedge clk);
    #1;
  endtask

  function automatic wb_entry_t rand_entry();
    wb_entry_t e;
    e.res_a   = $urandom;
    e.res_b   = $urandom;
    e.wr_a    = 1'($urandom_range(0, 1));
    e.wr_b    = 1'($urandom_range(0, 1));
    e.dest_a  = 5'($urandom);
    e.dest_b  = 5'($urandom);
    e.wr_crf  = 1'($urandom_range(0, 1));
    e.crf_sel = 3'($urandom);
    e.crf     = 4'($urandom);
    return e;
  endfunction

  initial begin
    wb_entry_t e;
    wb_entry_t idle;
    int ready_pct;
    idle = '0;

    applyStimulus(0, idle, 0, 1);
    applyStimulus(0, idle, 0, 1);
    applyStimulus(0, idle, 1, 0);

    // Single write
    e = '0; e.wr_a = 1; e.dest_a = 5'd3; e.res_a = 32'hDEADBEEF;
    applyStimulus(1, e, 1, 0);
    repeat (2) applyStimulus(0, idle, 1, 0);

    // Dual write with CR field
    e = '0; e.wr_a = 1; e.wr_b = 1; e.dest_a = 5'd1; e.dest_b = 5'd2;
    e.res_a = 32'h11; e.res_b = 32'h22; e.wr_crf = 1; e.crf_sel = 3'd5; e.crf = 4'h8;
    applyStimulus(1, e, 1, 0);
    repeat (3) applyStimulus(0, idle, 1, 0);

    // Backpressure on a pending dual write
    applyStimulus(1, e, 0, 0);
    repeat (3) applyStimulus(0, idle, 0, 0);
    repeat (3) applyStimulus(0, idle, 1, 0);

    // Fill to full, overflow on the fifth, then drain
    for (int i = 0; i < 5; i++) begin
      e = '0; e.wr_a = 1; e.dest_a = 5'(i + 8); e.res_a = 32'hA000 + i;
      applyStimulus(1, e, 0, 0);
    end
    repeat (2) applyStimulus(0, idle, 0, 0);
    repeat (6) applyStimulus(0, idle, 1, 0);
    applyStimulus(0, idle, 1, 1);

    // Back-to-back single writes wrapping the pointers
    for (int i = 0; i < 10; i++) begin
      e = '0; e.wr_a = 1; e.dest_a = 5'(i); e.res_a = 32'(i);
      applyStimulus(1, e, 1, 0);
    end
    repeat (2) applyStimulus(0, idle, 1, 0);

    // Reset while three entries are queued
    for (int i = 0; i < 3; i++) begin
      e = '0; e.wr_a = 1; e.wr_crf = 1; e.dest_a = 5'(i + 20); e.res_a = 32'hC0 + i;
      applyStimulus(1, e, 0, 0);
    end
    applyStimulus(0, idle, 0, 1);
    repeat (4) applyStimulus(0, idle, 1, 0);

    // Random traffic in segments with varying readiness
    for (int seg = 0; seg < 6; seg++) begin
      ready_pct = $urandom_range(20, 100);
      for (int c = 0; c < 400; c++) begin
        bit v;
        if (model_q.size() == DEPTH) v = ($urandom_range(0, 99) < 3);
        else v = ($urandom_range(0, 99) < 65);
        applyStimulus(v, rand_entry(), ($urandom_range(1, 100) <= ready_pct), 0);
      end
      repeat (12) applyStimulus(0, idle, 1, 0);
      applyStimulus(0, idle, 1, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/result_writeback.md
Name: result_writeback

Overview:
- Consumer end of the functional-unit result bus. Accepts one result per cycle from an FU output (res_a, res_b, CR field) and buffers it in a small FIFO.
- Drains each result into the single-ported GPR write port, taking up to two beats per result. CR field writes go to a separate port.
- Asserts stall toward issue when it cannot accept another result.
- Sits between the FU result buses (e.g. the NVE unit) and the register file.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- GPR_AW, 5, GPR address width.
- CRF_FIELDS, 8, number of 4-bit CR fields; field select width is clog2(CRF_FIELDS).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rb_valid  in  1  result present this cycle
- rb_res_a  in  32  primary result
- rb_res_b  in  32  secondary result
- rb_wr_a / rb_wr_b  in  1 each  write res_a / res_b to GPR
- rb_dest_a / rb_dest_b  in  GPR_AW each  GPR targets
- rb_wr_crf  in  1  write a CR field
- rb_crf_sel  in  clog2(CRF_FIELDS)  CR field index
- rb_crf  in  4  CR field value
- stall  out  1  FIFO full; upstream must not assert rb_valid
- gpr_we  out  1  GPR write request
- gpr_waddr  out  GPR_AW  GPR write address
- gpr_wdata  out  32  GPR write data
- gpr_ready  in  1  register file accepts the write this cycle
- crf_we  out  1  CR field write; always accepted
- crf_sel  out  clog2(CRF_FIELDS)  CR field index
- crf_wdata  out  4  CR field value
- overflow_err  out  1  sticky; set on rb_valid while stall

Behaviour:
- Reset (synchronous, active-high):
  - FIFO emptied; rd/wr pointers and count go to 0; phase FSM goes to PH_A; overflow_err cleared.
  - All outputs 0 in the cycle after reset is sampled.
  - Reset mid-drain discards all pending entries. No partial beat is replayed.
- Enqueue:
  - Condition: rb_valid && !stall.
  - All rb_* fields are written at wr_ptr; count increments.
  - stall = (count == DEPTH), driven from registered count.
  - If rb_valid && stall: the entry is dropped and overflow_err is set until reset.
- Dequeue FSM (acts on head entry only):
  - PH_A, head has wr_a:
    - gpr_we=1, waddr=dest_a, wdata=res_a.
    - If the head has wr_crf, crf_we pulses in the first cycle of PH_A only, whether or not gpr_ready is high.
    - On gpr_ready: go to PH_B if wr_b, else pop and stay in PH_A.
  - PH_A, head has !wr_a && wr_b: behaves as PH_B directly. CR write is issued in the first cycle of that phase.
  - PH_B:
    - gpr_we=1, waddr=dest_b, wdata=res_b.
    - On gpr_ready: pop, go to PH_A.
  - Head with no GPR writes:
    - crf_we per wr_crf for one cycle, then pop.
    - An entry with no writes at all pops in one cycle with no outputs.
  - Track the CR write with an internal crf_done flag, cleared on pop, so crf_we fires exactly once per entry.
- Outputs are combinational from the FIFO head and FSM.
- Latency: an entry enqueued in cycle N drives gpr_we in cycle N+1 at the earliest. There is no bypass when empty.
- Enqueue and pop in the same cycle: count unchanged. Allowed at any count below DEPTH; when full, only pop occurs.
- Pointers wrap modulo DEPTH.
- gpr_ready low holds gpr_we/waddr/wdata stable until accepted.
- Write order matches enqueue order; a result's A beat always precedes its B beat.
- Throughput: 1 result/cycle for single-GPR results; 2 cycles for dual-GPR results with gpr_ready held high.

Decomposition:
- Shared package Backend gets:
  - Wb_entry typedef: res_a, res_b, wr_a, wr_b, dest_a, dest_b, wr_crf, crf_sel, crf.
  - Wb_phase enum {PH_A, PH_B}.
- One sub-module, wb_fifo: a generic synchronous FIFO parameterized by DEPTH and the element type. It provides push, pop, head, count, full and empty.
- The phase FSM and output muxing stay in result_writeback.

Test Plan:
- Single write: rb_valid, wr_a=1, dest_a=3, res_a=0xDEADBEEF, gpr_ready=1 -> next cycle gpr_we=1, waddr=3, wdata=0xDEADBEEF for one cycle; FIFO empty after.
- Dual write with CR: wr_a, wr_b, dest_a=1, dest_b=2, res_a=0x11, res_b=0x22, wr_crf, crf_sel=5, crf=0x8 -> cycle 1: GPR1=0x11 with crf_we, sel=5, data=0x8; cycle 2: GPR2=0x22; crf_we low in cycle 2.
- Backpressure: gpr_ready=0 for 3 cycles with a pending write -> outputs held constant; crf_we pulses once only; write completes on the cycle gpr_ready goes high.
- Fill: DEPTH=4, gpr_ready=0, push 4 results -> stall=1 after the 4th. A 5th rb_valid sets overflow_err and that entry never appears. Releasing gpr_ready drains 4 writes in order.
- Wrap and concurrent: gpr_ready=1, push 10 single-write results back to back (dest=i, res=i) -> writes i=0..9 in order, one per cycle; stall stays 0.
- Reset mid-drain: 3 entries queued, assert reset for 1 cycle -> next cycle gpr_we=0, crf_we=0, stall=0, overflow_err=0; no stale writes afterwards.
